// File: rtl/mc_control_unit.sv
// Multicycle control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back for a small RV32I subset. Outputs decode from the
// current state, gated only by mem_ready / isTrue and the latched instruction.
module mc_control_unit #(
  parameter int DATAWIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        isTrue,
  output logic [3:0]  alu_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_type,
  output logic [1:0]  result_src,
  output logic        pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        illegal
);

  // The datapath this unit steers must hold a full 32-bit instruction word.
  if (DATAWIDTH < 32) begin : g_width_check
    $error("mc_control_unit: DATAWIDTH must be at least 32");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_EQ  = 4'b1000,
                         ALU_NE  = 4'b1001, ALU_LT  = 4'b1010, ALU_GE  = 4'b1011;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011;

  state_t state_q, state_d;
  // Set on the first edge after reset release so FETCH starts on the second.
  logic   armed_q, armed_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       is_store;
  logic [3:0] arith_op;
  logic       arith_ok;
  logic [3:0] branch_op;
  logic       branch_ok;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign alt      = instr[30];
  assign is_store = (opcode == OP_STORE);
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Register-register / register-immediate ALU operation from funct3/funct7.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    arith_op = ALU_ADD;
    arith_ok = 1'b1;
    case (funct3)
      3'b000:  arith_op = ((opcode == OP_R) && alt) ? ALU_SUB : ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b100:  arith_op = ALU_XOR;
      3'b001:  arith_op = ALU_SLL;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b010:  arith_op = ALU_LT;
      default: arith_ok = 1'b0;  // unsigned compare is not supported
    endcase
  end

  // Branch comparison from funct3; unsigned forms are not supported.
  always_comb begin
    branch_op = ALU_ADD;
    branch_ok = 1'b1;
    case (funct3)
      3'b000:  branch_op = ALU_EQ;
      3'b001:  branch_op = ALU_NE;
      3'b100:  branch_op = ALU_LT;
      3'b101:  branch_op = ALU_GE;
      default: branch_ok = 1'b0;
    endcase
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d     = state_q;
    armed_d     = 1'b1;
    alu_control = ALU_ADD;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_type    = IMM_I;
    result_src  = 2'b00;
    pc_src      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (armed_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_type  = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default:            state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = arith_op;
        state_d     = arith_ok ? S_ALU_WB : S_HALT;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = arith_op;
        state_d     = arith_ok ? S_ALU_WB : S_HALT;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_type  = is_store ? IMM_S : IMM_I;
        if (funct3 != 3'b010) state_d = S_HALT;  // word accesses only
        else                  state_d = is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = branch_op;
        pc_src      = 1'b1;
        pc_write    = branch_ok & isTrue;
        state_d     = branch_ok ? S_FETCH : S_HALT;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops straight to IDLE so outputs clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: table of instructions walked through
// the FSM with per-cycle expected control words, plus wait/reset sequences.
module tb_mc_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        is_true;
  logic [3:0]  alu_control;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_type;
  logic        pc_src, mem_read, mem_write, ir_write, pc_write, reg_write, illegal;

  mc_control_unit #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .isTrue(is_true),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_type(imm_type), .result_src(result_src), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [1:0] rs;
    logic       pcs;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write, illegal;
  } ctl_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        is_true;
    ctl_t        dec;
    int          n;
    ctl_t [2:0]  post;
    logic        halts;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vq[$];

  function automatic ctl_t mk(input logic [3:0] alu, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] imm, input logic [1:0] rs, input logic pcs,
                              input logic [5:0] stb);
    ctl_t c;
    c.alu = alu; c.sa = sa; c.sb = sb; c.imm = imm; c.rs = rs; c.pcs = pcs;
    {c.mem_read, c.mem_write, c.ir_write, c.pc_write, c.reg_write, c.illegal} = stb;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.alu = alu_control; c.sa = alu_src_a; c.sb = alu_src_b; c.imm = imm_type;
    c.rs = result_src; c.pcs = pc_src;
    {c.mem_read, c.mem_write, c.ir_write, c.pc_write, c.reg_write, c.illegal} =
      {mem_read, mem_write, ir_write, pc_write, reg_write, illegal};
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string name, input ctl_t exp);
    check(name, 32'(sample()), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected control words (fields: alu, src_a, src_b, imm, result_src, pc_src,
  // {mem_read, mem_write, ir_write, pc_write, reg_write, illegal}).
  ctl_t idle_w, fetch_w, fetch_wait_w, halt_w, dec_b, dec_j, wb_alu, jal_w;
  ctl_t ma_l, ma_s, mrd_w, mwb_w, mwr_w;

  function automatic ctl_t ex_r(input logic [3:0] alu);
    return mk(alu, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000000);
  endfunction
  function automatic ctl_t ex_i(input logic [3:0] alu);
    return mk(alu, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 6'b000000);
  endfunction
  function automatic ctl_t br(input logic [3:0] alu, input logic pw);
    return mk(alu, 2'b10, 2'b00, 3'b000, 2'b00, 1'b1, {3'b000, pw, 2'b00});
  endfunction

  task automatic add(input string name, input logic [31:0] ins, input logic t, input ctl_t dec,
                     input int n, input ctl_t p0, input ctl_t p1, input ctl_t p2, input logic h);
    vec_t v;
    v.name = name; v.instr = ins; v.is_true = t; v.dec = dec; v.n = n;
    v.post[0] = p0; v.post[1] = p1; v.post[2] = p2; v.halts = h;
    vq.push_back(v);
  endtask

  // Assert reset, release it, and land on a negedge with the FSM in FETCH.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_ctl({tag, "_reset_state"}, idle_w);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_ctl({tag, "_idle_first_edge"}, idle_w);
    step();
    check_ctl({tag, "_fetch_second_edge"}, fetch_w);
  endtask

  // Entry: at a negedge in FETCH. Exit: same, after the instruction retires.
  task automatic run_vec(input vec_t v);
    instr = v.instr;
    is_true = v.is_true;
    mem_ready = 1'b1;
    #1;
    check_ctl({v.name, "_fetch"}, fetch_w);
    step();
    check_ctl({v.name, "_decode"}, v.dec);
    for (int k = 0; k < v.n; k++) begin
      step();
      check_ctl($sformatf("%s_c%0d", v.name, k + 3), v.post[k]);
    end
    if (v.halts) begin
      repeat (3) step();
      check_ctl({v.name, "_halt_sticky"}, halt_w);
      do_reset(v.name);
    end else begin
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cycles;
    idle_w       = mk(4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000000);
    fetch_w      = mk(4'b0000, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 6'b101100);
    fetch_wait_w = mk(4'b0000, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 6'b100000);
    halt_w       = mk(4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000001);
    dec_b        = mk(4'b0000, 2'b01, 2'b01, 3'b010, 2'b00, 1'b0, 6'b000000);
    dec_j        = mk(4'b0000, 2'b01, 2'b01, 3'b011, 2'b00, 1'b0, 6'b000000);
    wb_alu       = mk(4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000010);
    jal_w        = mk(4'b0000, 2'b01, 2'b10, 3'b000, 2'b10, 1'b1, 6'b000110);
    ma_l         = mk(4'b0000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 6'b000000);
    ma_s         = mk(4'b0000, 2'b10, 2'b01, 3'b001, 2'b00, 1'b0, 6'b000000);
    mrd_w        = mk(4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 6'b100000);
    mwb_w        = mk(4'b0000, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 6'b000010);
    mwr_w        = mk(4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 6'b010000);

    add("add",   32'h002081B3, 1'b0, dec_b, 2, ex_r(4'b0000), wb_alu, idle_w, 1'b0);
    add("sub",   32'h402081B3, 1'b0, dec_b, 2, ex_r(4'b0001), wb_alu, idle_w, 1'b0);
    add("and",   32'h0020F1B3, 1'b0, dec_b, 2, ex_r(4'b0010), wb_alu, idle_w, 1'b0);
    add("or",    32'h0020E1B3, 1'b0, dec_b, 2, ex_r(4'b0011), wb_alu, idle_w, 1'b0);
    add("xor",   32'h0020C1B3, 1'b0, dec_b, 2, ex_r(4'b0100), wb_alu, idle_w, 1'b0);
    add("sll",   32'h002091B3, 1'b0, dec_b, 2, ex_r(4'b0101), wb_alu, idle_w, 1'b0);
    add("srl",   32'h0020D1B3, 1'b0, dec_b, 2, ex_r(4'b0110), wb_alu, idle_w, 1'b0);
    add("sra",   32'h4020D1B3, 1'b0, dec_b, 2, ex_r(4'b0111), wb_alu, idle_w, 1'b0);
    add("slt",   32'h0020A1B3, 1'b0, dec_b, 2, ex_r(4'b1010), wb_alu, idle_w, 1'b0);
    add("sltu",  32'h0020B1B3, 1'b0, dec_b, 2, ex_r(4'b0000), halt_w, idle_w, 1'b1);
    add("addi",  32'h00508193, 1'b0, dec_b, 2, ex_i(4'b0000), wb_alu, idle_w, 1'b0);
    add("addin", 32'hC0008193, 1'b0, dec_b, 2, ex_i(4'b0000), wb_alu, idle_w, 1'b0);
    add("xori",  32'h0050C193, 1'b0, dec_b, 2, ex_i(4'b0100), wb_alu, idle_w, 1'b0);
    add("srli",  32'h0020D193, 1'b0, dec_b, 2, ex_i(4'b0110), wb_alu, idle_w, 1'b0);
    add("srai",  32'h4020D193, 1'b0, dec_b, 2, ex_i(4'b0111), wb_alu, idle_w, 1'b0);
    add("sltiu", 32'h0050B193, 1'b0, dec_b, 2, ex_i(4'b0000), halt_w, idle_w, 1'b1);
    add("beq_t", 32'h00208463, 1'b1, dec_b, 1, br(4'b1000, 1'b1), idle_w, idle_w, 1'b0);
    add("beq_f", 32'h00208463, 1'b0, dec_b, 1, br(4'b1000, 1'b0), idle_w, idle_w, 1'b0);
    add("bne_t", 32'h00209463, 1'b1, dec_b, 1, br(4'b1001, 1'b1), idle_w, idle_w, 1'b0);
    add("blt_t", 32'h0020C463, 1'b1, dec_b, 1, br(4'b1010, 1'b1), idle_w, idle_w, 1'b0);
    add("bge_f", 32'h0020D463, 1'b0, dec_b, 1, br(4'b1011, 1'b0), idle_w, idle_w, 1'b0);
    add("b_bad", 32'h0020A463, 1'b0, dec_b, 2, br(4'b0000, 1'b0), halt_w, idle_w, 1'b1);
    add("jal",   32'h008000EF, 1'b0, dec_j, 1, jal_w, idle_w, idle_w, 1'b0);
    add("lw",    32'h0040A283, 1'b0, dec_b, 3, ma_l, mrd_w, mwb_w, 1'b0);
    add("sw",    32'h0050A223, 1'b0, dec_b, 2, ma_s, mwr_w, idle_w, 1'b0);
    add("lb",    32'h00008283, 1'b0, dec_b, 2, ma_l, halt_w, idle_w, 1'b1);
    add("sb",    32'h00508223, 1'b0, dec_b, 2, ma_s, halt_w, idle_w, 1'b1);
    add("ones",  32'hFFFFFFFF, 1'b0, dec_b, 1, halt_w, idle_w, idle_w, 1'b1);

    rst_n = 1'b0;
    instr = 32'h0;
    is_true = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    do_reset("init");

    foreach (vq[i]) run_vec(vq[i]);

    // Fetch stalls while memory is busy: no ir_write/pc_write until ready.
    instr = 32'h002081B3;
    mem_ready = 1'b0;
    #1;
    check_ctl("fetch_wait_0", fetch_wait_w);
    step();
    check_ctl("fetch_wait_1", fetch_wait_w);
    mem_ready = 1'b1;
    #1;
    check_ctl("fetch_wait_done", fetch_w);
    step();
    check_ctl("fetch_wait_decode", dec_b);
    repeat (3) step();

    // Load with memory busy for three cycles in MEM_RD.
    instr = 32'h0040A283;
    step();
    step();
    step();
    check_ctl("lw_wait_enter", mrd_w);
    rd_cycles = 0;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (mem_read) rd_cycles++;
      step();
    end
    mem_ready = 1'b1;
    #1;
    if (mem_read) rd_cycles++;
    check("lw_mem_read_cycles", 32'(rd_cycles), 32'd4);
    step();
    check_ctl("lw_wait_wb", mwb_w);
    step();
    check_ctl("lw_wait_back_fetch", fetch_w);

    // Store with memory busy for two cycles in MEM_WR.
    instr = 32'h0050A223;
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    check_ctl("sw_wait_0", mwr_w);
    step();
    check_ctl("sw_wait_1", mwr_w);
    mem_ready = 1'b1;
    step();
    check_ctl("sw_wait_back_fetch", fetch_w);

    // Reset asserted mid-cycle while fetch waits on memory.
    mem_ready = 1'b0;
    #1;
    check("async_pre_mem_read", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mem_read_drop", 32'(mem_read), 32'd0);
    @(negedge clk);
    do_reset("async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, datapath width; instruction width fixed at 32.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: instr  in  32  instruction register contents, valid from DECODE onward.
REQ-005 SHALL have ports: mem_ready  in  1  memory access completes this cycle.
REQ-006 SHALL have ports: isTrue  in  1  ALU comparison result (Result != 0).
REQ-007 SHALL have ports: alu_control  out  4  ALU opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 EQ, 1001 NE, 1010 LT(signed), 1011 GE(signed).
REQ-008 SHALL have ports: alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
REQ-009 SHALL have ports: alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-010 SHALL have ports: imm_type  out  3  000 I, 001 S, 010 B, 011 J.
REQ-011 SHALL have ports: result_src  out  2  00 ALUOut, 01 memory read data, 10 ALU result.
REQ-012 SHALL have ports: pc_src  out  1  0 ALU result, 1 ALUOut.
REQ-013 SHALL have ports: mem_read, mem_write, ir_write, pc_write, reg_write  out  1 each  single-cycle strobes.
REQ-014 SHALL have ports: illegal  out  1  sticky unsupported-instruction flag.

Function
REQ-015 SHALL be a Moore FSM, states IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, HALT; outputs decode from state plus mem_ready/isTrue gating only.
REQ-016 IDLE: all strobes 0; next state FETCH unconditionally.
REQ-017 FETCH: mem_read=1, alu_src_a=00, alu_src_b=10, ADD; stay while mem_ready=0; on mem_ready=1 assert ir_write=1, pc_write=1, pc_src=0 that cycle and go DECODE.
REQ-018 DECODE: alu_src_a=01, alu_src_b=01, imm_type=B or J per opcode, ADD (target into ALUOut); dispatch on instr[6:0]: 0110011 EXEC_R, 0010011 EXEC_I, 0000011/0100011 MEM_ADDR, 1100011 BRANCH, 1101111 JAL, else HALT.
REQ-019 R/I decode: funct3 000 ADD (SUB if R and funct7[5]=1), 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL/SRA by funct7[5], 010 LT; funct3 011 SHALL go HALT.
REQ-020 EXEC_R: src_a=10, src_b=00; EXEC_I: src_a=10, src_b=01, imm_type=I; both go ALU_WB.
REQ-021 ALU_WB: reg_write=1, result_src=00; go FETCH.
REQ-022 MEM_ADDR: src_a=10, src_b=01, ADD, imm_type I (load) or S (store); funct3!=010 SHALL go HALT; else MEM_RD (load) or MEM_WR (store).
REQ-023 MEM_RD: mem_read=1 until mem_ready, then MEM_WB; MEM_WB: reg_write=1, result_src=01, go FETCH.
REQ-024 MEM_WR: mem_write=1 until mem_ready, then FETCH.
REQ-025 BRANCH: src_a=10, src_b=00; funct3 000 EQ, 001 NE, 100 LT, 101 GE, other HALT; pc_write=isTrue with pc_src=1; go FETCH.
REQ-026 JAL: src_a=01, src_b=10, ADD; reg_write=1, result_src=10, pc_write=1, pc_src=1; go FETCH.
REQ-027 HALT: illegal=1, all strobes 0, remain until reset.
REQ-028 Strobes SHALL be 0 in every state not listed above; alu_control SHALL be ADD where unspecified.

Reset
REQ-029 rst_n low SHALL force IDLE immediately, regardless of state, including mid-wait on mem_ready.
REQ-030 During reset: all strobes 0, illegal 0, alu_control 0000, all selects 0.
REQ-031 First FETCH SHALL occur on the second rising edge after rst_n deasserts.

Verification
REQ-032 0x002081B3 (add x3,x1,x2), mem_ready=1 -> FETCH,DECODE,EXEC_R(0000),ALU_WB reg_write=1; 4 cycles.
REQ-033 0x402081B3 -> EXEC_R alu_control=0001.
REQ-034 0x00208463 (beq +8), isTrue=1 -> BRANCH alu_control=1000, pc_write=1, pc_src=1; isTrue=0 -> pc_write=0.
REQ-035 0x0040A283 (lw), mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, then MEM_WB reg_write=1, result_src=01.
REQ-036 0xFFFFFFFF -> HALT, illegal=1 sticky; rst_n pulse -> illegal=0, IDLE.
REQ-037 rst_n asserted during FETCH wait -> mem_read drops without clock edge.
